// File: rtl/fb_axi_read_responder.sv
// fb_axi_read_responder: AXI4 read-only slave that streams framebuffer and
// texture bursts out of a single-port synchronous RAM, one burst at a time.
module fb_axi_read_responder #(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h01E0_0000
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [31:0]               s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd,
    input  logic [31:0]               mem_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    logic [0:0]          state_q, state_d;
    logic                arready_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [30:0]         waddr_q, waddr_d;
    logic [8:0]          left_q, left_d;
    logic                fixed_q;
    logic                slverr_q;

    logic                infl_q;
    logic [1:0]          infl_resp_q;
    logic                infl_last_q;

    logic [1:0]          occ_q, occ_d;
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [31:0]         fifo_data_q [2];
    logic [1:0]          fifo_resp_q [2];
    logic                fifo_last_q [2];

    logic [32:0]         ar_diff;
    logic                ar_hs;
    logic                in_range;
    logic                can_issue;
    logic                issue;
    logic                head_valid;
    logic                pop;
    logic                pop_fifo;
    logic                push;
    logic [31:0]         infl_data;
    logic [31:0]         head_data;
    logic [1:0]          head_resp;
    logic                head_last;

    assign ar_hs   = s_axi_arvalid && arready_q;
    assign ar_diff = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};

    // Word offset is signed: any bit at or above the window width means
    // the beat falls below the base or past the top of the RAM.
    assign in_range = (waddr_q >> MEM_ADDR_WIDTH) == '0;

    assign can_issue = ({1'b0, occ_q} + {2'b00, infl_q}) < 3'd2;
    assign issue     = (state_q == ST_BURST) && (left_q != 9'd0) && can_issue;

    assign mem_rd   = issue && !slverr_q && in_range;
    assign mem_addr = waddr_q[MEM_ADDR_WIDTH-1:0];

    // The beat issued last cycle is presented directly when the buffer is
    // empty, so the RAM's one-cycle latency costs no extra R cycle.
    assign infl_data  = (infl_resp_q == RESP_OKAY) ? mem_rdata : 32'd0;
    assign head_valid = (occ_q != 2'd0) || infl_q;
    assign pop        = head_valid && s_axi_rready;
    assign pop_fifo   = pop && (occ_q != 2'd0);
    assign push       = infl_q && !((occ_q == 2'd0) && pop);
    assign occ_d      = occ_q + {1'b0, push} - {1'b0, pop_fifo};

    always_comb begin
        head_data = 32'd0;
        head_resp = RESP_OKAY;
        head_last = 1'b0;
        if (occ_q != 2'd0) begin
            head_data = fifo_data_q[rd_ptr_q];
            head_resp = fifo_resp_q[rd_ptr_q];
            head_last = fifo_last_q[rd_ptr_q];
        end else if (infl_q) begin
            head_data = infl_data;
            head_resp = infl_resp_q;
            head_last = infl_last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        left_d  = left_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = ST_BURST;
                    waddr_d = 31'(ar_diff >> 2);
                    left_d  = {1'b0, s_axi_arlen} + 9'd1;
                end
            end
            ST_BURST: begin
                if (issue) begin
                    left_d = left_q - 9'd1;
                    if (!fixed_q) begin
                        waddr_d = waddr_q + 31'd1;
                    end
                end
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            arready_q   <= 1'b0;
            id_q        <= '0;
            waddr_q     <= '0;
            left_q      <= '0;
            fixed_q     <= 1'b0;
            slverr_q    <= 1'b0;
            infl_q      <= 1'b0;
            infl_resp_q <= RESP_OKAY;
            infl_last_q <= 1'b0;
            occ_q       <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == ST_IDLE);
            waddr_q   <= waddr_d;
            left_q    <= left_d;
            if (ar_hs) begin
                id_q     <= s_axi_arid;
                fixed_q  <= (s_axi_arburst == 2'd0);
                slverr_q <= (s_axi_arsize != 3'd2) || (s_axi_arburst >= 2'd2);
            end
            infl_q <= issue;
            if (issue) begin
                infl_resp_q <= slverr_q ? RESP_SLVERR :
                               (in_range ? RESP_OKAY : RESP_DECERR);
                infl_last_q <= (left_q == 9'd1);
            end
            occ_q <= occ_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_fifo) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= infl_data;
            fifo_resp_q[wr_ptr_q] <= infl_resp_q;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = head_data;
    assign s_axi_rresp   = head_resp;
    assign s_axi_rlast   = head_last;
    assign s_axi_rvalid  = head_valid;

endmodule

// File: tb/tb_fb_axi_read_responder.sv
// tb_fb_axi_read_responder: directed bench for the framebuffer AXI read
// responder with a one-cycle-latency RAM model.
module tb_fb_axi_read_responder;

    localparam logic [31:0] BASE = 32'h01E0_0000;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = 2'd1;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;

    fb_axi_read_responder #(
        .ID_WIDTH(4),
        .MEM_ADDR_WIDTH(14),
        .BASE_ADDR(BASE)
    ) dut (
        .aclk(aclk),
        .resetn(resetn),
        .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;

    logic [31:0] ram [0:16383];
    logic [13:0] log_addr [256];
    int          mem_rd_cnt = 0;
    int          cyc = 0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (mem_rd) begin
            mem_rdata <= ram[mem_addr];
            log_addr[mem_rd_cnt % 256] <= mem_addr;
            mem_rd_cnt <= mem_rd_cnt + 1;
        end
    end

    int passed = 0;
    int total = 0;

    logic [31:0] cap_data [64];
    logic [1:0]  cap_resp [64];
    logic        cap_last [64];
    logic [3:0]  cap_id   [64];
    int          cap_cyc  [64];
    int          got;
    int          stab_err;
    int          max_out;

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst,
                         output int hs_cyc, output bit ok);
        logic seen;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        ok = 1'b0;
        hs_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            seen = s_axi_arready;
            @(posedge aclk);
            #1;
            if (seen) begin
                ok = 1'b1;
                hs_cyc = cyc;
                break;
            end
        end
        s_axi_arvalid = 1'b0;
    endtask

    // mode 0: rready held high; mode 1: 1,0,0,1 pattern with a 10-cycle stall
    task automatic collect(input int n, input int mode);
        int t;
        int base;
        int outst;
        logic rr;
        logic pv;
        logic pr;
        logic [31:0] pd;
        logic [1:0] pp;
        logic pl;
        t = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        pp = '0;
        pl = 1'b0;
        got = 0;
        stab_err = 0;
        max_out = 0;
        base = mem_rd_cnt;
        while (got < n && t < 400) begin
            if (mode == 0) rr = 1'b1;
            else if (t >= 8 && t < 18) rr = 1'b0;
            else rr = ((t % 4) == 0 || (t % 4) == 3) ? 1'b1 : 1'b0;
            s_axi_rready = rr;
            if (pv && !pr && (!s_axi_rvalid || s_axi_rdata !== pd ||
                s_axi_rresp !== pp || s_axi_rlast !== pl))
                stab_err++;
            outst = (mem_rd_cnt - base) - got;
            if (outst > max_out) max_out = outst;
            if (s_axi_rvalid && rr) begin
                cap_data[got] = s_axi_rdata;
                cap_resp[got] = s_axi_rresp;
                cap_last[got] = s_axi_rlast;
                cap_id[got]   = s_axi_rid;
                cap_cyc[got]  = cyc;
                got++;
            end
            pv = s_axi_rvalid;
            pr = rr;
            pd = s_axi_rdata;
            pp = s_axi_rresp;
            pl = s_axi_rlast;
            if (got < n) begin
                @(posedge aclk);
                #1;
                t++;
            end
        end
        s_axi_arvalid = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if ({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp,
             s_axi_rid, mem_rd} !== 10'd0) begin
            $display("FAIL reset_ctrl: got %b want 0", {s_axi_arready,
                     s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid, mem_rd});
        end else passed++;
        total++;
        if (s_axi_rdata !== 32'd0)
            $display("FAIL reset_rdata: got %h want 0", s_axi_rdata);
        else passed++;
        total++;
        if (mem_addr !== 14'd0)
            $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        else passed++;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        total++;
        if (s_axi_arready !== 1'b1)
            $display("FAIL reset_arready_rise: got %b want 1", s_axi_arready);
        else passed++;
    endtask

    task automatic test_single();
        int hs;
        bit ok;
        ram[4] = 32'hDEAD_BEEF;
        s_axi_rready = 1'b0;
        do_ar(4'hA, 32'h01E0_0010, 8'd0, 3'd2, 2'd1, hs, ok);
        total++;
        if (!ok) $display("FAIL single_ar: got no handshake want handshake");
        else passed++;
        total++;
        if ({s_axi_arready, mem_rd, mem_addr, s_axi_rvalid} !== {1'b0, 1'b1, 14'd4, 1'b0})
            $display("FAIL single_issue: got ar=%b rd=%b addr=%0d rv=%b want 0 1 4 0",
                     s_axi_arready, mem_rd, mem_addr, s_axi_rvalid);
        else passed++;
        s_axi_rready = 1'b1;
        @(posedge aclk);
        #1;
        total++;
        if (s_axi_rvalid !== 1'b1 || cyc !== hs + 1)
            $display("FAIL single_latency: got rvalid=%b at +%0d want 1 at +1",
                     s_axi_rvalid, cyc - hs);
        else passed++;
        total++;
        if ({s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid} !==
            {32'hDEAD_BEEF, 2'd0, 1'b1, 4'hA})
            $display("FAIL single_beat: got %h/%0d/%b/%h want deadbeef/0/1/a",
                     s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid);
        else passed++;
        @(posedge aclk);
        #1;
        total++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01)
            $display("FAIL single_done: got rv=%b ar=%b want 0 1",
                     s_axi_rvalid, s_axi_arready);
        else passed++;
    endtask

    task automatic test_incr16();
        int hs;
        bit ok;
        int bad;
        int lbad;
        for (int i = 0; i < 16; i++) ram[i] = i;
        do_ar(4'h3, BASE, 8'd15, 3'd2, 2'd1, hs, ok);
        collect(16, 0);
        total++;
        if (!ok || got !== 16)
            $display("FAIL incr16_count: got %0d beats want 16", got);
        else passed++;
        bad = 0;
        lbad = 0;
        for (int i = 0; i < 16; i++) begin
            if (cap_data[i] !== 32'(i) || cap_resp[i] !== 2'd0) bad++;
            if (cap_last[i] !== (i == 15)) lbad++;
        end
        total++;
        if (bad !== 0) $display("FAIL incr16_data: got %0d bad beats want 0", bad);
        else passed++;
        total++;
        if (lbad !== 0) $display("FAIL incr16_rlast: got %0d bad rlast want 0", lbad);
        else passed++;
        total++;
        if (cap_cyc[0] !== hs + 1 || cap_cyc[15] - cap_cyc[0] !== 15)
            $display("FAIL incr16_timing: got first +%0d span %0d want +1 span 15",
                     cap_cyc[0] - hs, cap_cyc[15] - cap_cyc[0]);
        else passed++;
        total++;
        if (s_axi_arready !== 1'b1)
            $display("FAIL incr16_idle: got arready %b want 1", s_axi_arready);
        else passed++;
    endtask

    task automatic test_backpressure();
        int hs;
        bit ok;
        int bad;
        do_ar(4'h5, BASE, 8'd15, 3'd2, 2'd1, hs, ok);
        collect(16, 1);
        total++;
        if (!ok || got !== 16)
            $display("FAIL bp_count: got %0d beats want 16", got);
        else passed++;
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (cap_data[i] !== 32'(i) || cap_last[i] !== (i == 15) ||
                cap_id[i] !== 4'h5) bad++;
        total++;
        if (bad !== 0) $display("FAIL bp_sequence: got %0d bad beats want 0", bad);
        else passed++;
        total++;
        if (stab_err !== 0)
            $display("FAIL bp_stable: got %0d changes during stall want 0", stab_err);
        else passed++;
        total++;
        if (max_out !== 2)
            $display("FAIL bp_outstanding: got max %0d want 2", max_out);
        else passed++;
        s_axi_rready = 1'b0;
    endtask

    task automatic test_errors();
        int hs;
        bit ok;
        int b0;
        int bad;
        b0 = mem_rd_cnt;
        do_ar(4'h1, BASE, 8'd3, 3'd1, 2'd1, hs, ok);
        collect(4, 0);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (cap_resp[i] !== 2'd2 || cap_data[i] !== 32'd0 ||
                cap_last[i] !== (i == 3)) bad++;
        total++;
        if (!ok || got !== 4 || bad !== 0)
            $display("FAIL err_size: got %0d beats %0d bad want 4 beats 0 bad", got, bad);
        else passed++;
        total++;
        if (mem_rd_cnt !== b0)
            $display("FAIL err_size_rd: got %0d reads want 0", mem_rd_cnt - b0);
        else passed++;

        ram[16383] = 32'hCAFE_F00D;
        b0 = mem_rd_cnt;
        do_ar(4'h2, 32'h01E0_FFFC, 8'd1, 3'd2, 2'd1, hs, ok);
        collect(2, 0);
        total++;
        if (!ok || got !== 2 || {cap_data[0], cap_resp[0], cap_last[0]} !==
            {32'hCAFE_F00D, 2'd0, 1'b0})
            $display("FAIL err_top_beat1: got %h/%0d want cafef00d/0",
                     cap_data[0], cap_resp[0]);
        else passed++;
        total++;
        if ({cap_data[1], cap_resp[1], cap_last[1]} !== {32'd0, 2'd3, 1'b1} ||
            mem_rd_cnt - b0 !== 1)
            $display("FAIL err_top_beat2: got %h/%0d reads %0d want 0/3 reads 1",
                     cap_data[1], cap_resp[1], mem_rd_cnt - b0);
        else passed++;

        b0 = mem_rd_cnt;
        do_ar(4'h3, 32'h01DF_FFFC, 8'd0, 3'd2, 2'd1, hs, ok);
        collect(1, 0);
        total++;
        if (!ok || got !== 1 || {cap_data[0], cap_resp[0], cap_last[0]} !==
            {32'd0, 2'd3, 1'b1} || mem_rd_cnt !== b0)
            $display("FAIL err_below: got %h/%0d reads %0d want 0/3 reads 0",
                     cap_data[0], cap_resp[0], mem_rd_cnt - b0);
        else passed++;

        do_ar(4'h4, 32'h01E0_0010, 8'd0, 3'd2, 2'd2, hs, ok);
        collect(1, 0);
        total++;
        if (!ok || got !== 1 || {cap_data[0], cap_resp[0]} !== {32'd0, 2'd2})
            $display("FAIL err_wrap: got %h/%0d want 0/2", cap_data[0], cap_resp[0]);
        else passed++;
    endtask

    task automatic test_fixed();
        int hs;
        bit ok;
        int b0;
        int bad;
        int abad;
        ram[7] = 32'h0000_0055;
        b0 = mem_rd_cnt;
        do_ar(4'h6, 32'h01E0_001C, 8'd3, 3'd2, 2'd0, hs, ok);
        collect(4, 0);
        bad = 0;
        abad = 0;
        for (int i = 0; i < 4; i++) begin
            if (cap_data[i] !== 32'h55 || cap_resp[i] !== 2'd0 ||
                cap_last[i] !== (i == 3)) bad++;
            if (log_addr[(b0 + i) % 256] !== 14'd7) abad++;
        end
        total++;
        if (!ok || got !== 4 || bad !== 0)
            $display("FAIL fixed_data: got %0d beats %0d bad want 4 beats 0 bad", got, bad);
        else passed++;
        total++;
        if (mem_rd_cnt - b0 !== 4 || abad !== 0)
            $display("FAIL fixed_addr: got %0d reads %0d off-addr want 4 reads 0",
                     mem_rd_cnt - b0, abad);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int hs;
        bit ok;
        ram[0] = 32'd0;
        ram[1] = 32'd1;
        ram[8] = 32'h0000_8888;
        do_ar(4'h5, BASE, 8'd1, 3'd2, 2'd1, hs, ok);
        s_axi_arid    = 4'h6;
        s_axi_araddr  = BASE + 32'h20;
        s_axi_arlen   = 8'd0;
        s_axi_arburst = 2'd1;
        s_axi_arvalid = 1'b1;
        collect(3, 0);
        total++;
        if (!ok || got !== 3 || {cap_data[0], cap_data[1], cap_data[2]} !==
            {32'd0, 32'd1, 32'h8888})
            $display("FAIL b2b_data: got %0d beats %h %h %h want 0 1 8888",
                     got, cap_data[0], cap_data[1], cap_data[2]);
        else passed++;
        total++;
        if ({cap_id[0], cap_id[1], cap_id[2], cap_last[0], cap_last[1], cap_last[2]} !==
            {4'h5, 4'h5, 4'h6, 1'b0, 1'b1, 1'b1})
            $display("FAIL b2b_id_last: got %h%h%h %b%b%b want 556 011",
                     cap_id[0], cap_id[1], cap_id[2], cap_last[0], cap_last[1], cap_last[2]);
        else passed++;
        total++;
        if (cap_cyc[2] - cap_cyc[1] !== 3)
            $display("FAIL b2b_gap: got %0d cycles want 3", cap_cyc[2] - cap_cyc[1]);
        else passed++;
        total++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01)
            $display("FAIL b2b_idle: got rv=%b ar=%b want 0 1", s_axi_rvalid, s_axi_arready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int hs;
        bit ok;
        int b0;
        int seen;
        for (int i = 0; i < 16; i++) ram[i] = i;
        b0 = mem_rd_cnt;
        do_ar(4'h7, BASE, 8'd15, 3'd2, 2'd1, hs, ok);
        collect(4, 0);
        s_axi_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if (!ok || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd4 ||
            mem_rd_cnt - b0 !== 6)
            $display("FAIL mid_stall: got rv=%b data=%h reads %0d want 1 4 6",
                     s_axi_rvalid, s_axi_rdata, mem_rd_cnt - b0);
        else passed++;
        resetn = 1'b0;
        @(posedge aclk);
        #1;
        total++;
        if ({s_axi_rvalid, s_axi_arready, mem_rd} !== 3'b000)
            $display("FAIL mid_reset: got rv=%b ar=%b rd=%b want 0 0 0",
                     s_axi_rvalid, s_axi_arready, mem_rd);
        else passed++;
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        total++;
        if ({s_axi_arready, s_axi_rvalid} !== 2'b10)
            $display("FAIL mid_release: got ar=%b rv=%b want 1 0",
                     s_axi_arready, s_axi_rvalid);
        else passed++;
        s_axi_rready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_axi_rvalid) seen++;
            @(posedge aclk);
            #1;
        end
        total++;
        if (seen !== 0) $display("FAIL mid_stale: got %0d stale beats want 0", seen);
        else passed++;
        ram[9] = 32'h9999_0009;
        do_ar(4'h2, BASE + 32'h24, 8'd0, 3'd2, 2'd1, hs, ok);
        collect(1, 0);
        total++;
        if (!ok || got !== 1 || {cap_data[0], cap_resp[0], cap_last[0], cap_id[0]} !==
            {32'h9999_0009, 2'd0, 1'b1, 4'h2})
            $display("FAIL mid_fresh: got %h/%0d/%b/%h want 99990009/0/1/2",
                     cap_data[0], cap_resp[0], cap_last[0], cap_id[0]);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = '0;
        test_reset();
        test_single();
        test_incr16();
        test_backpressure();
        test_errors();
        test_fixed();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
